side_ch_counter_sched: RTL and testbench

- Periodic snapshot scheduler for the six side-channel event counters.
- Every PERIOD cycles it captures counter0..5 one at a time. Each capture cycle also issues the matching clear write (register 26..31) into the counter block.
- It then streams the six snapshots out as a 6-beat valid/ready packet toward the side-channel DMA path.
- It arbitrates the counter-clear write bus between ARM register writes and its own clears. ARM always wins.

---
 rtl/side_ch_counter_sched_if.sv | 10 +
 rtl/side_ch_counter_sched.sv | 150 +++++++++++++++
 tb/tb_side_ch_counter_sched.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/side_ch_counter_sched_if.sv
// Snapshot stream toward the side-channel DMA path: 32-bit valid/ready beats with a last flag.
interface side_ch_counter_sched_if;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/side_ch_counter_sched.sv
// Periodic snapshot of six event counters with matching clears, streamed out as a 6-beat packet.
// Capture starts the cycle after a period tick; beats hold while m_tready is low; ARM writes stall capture.
module side_ch_counter_sched #(
  parameter int COUNTER_WIDTH = 16,
  parameter int PERIOD_WIDTH  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [PERIOD_WIDTH-1:0]  period,
  input  logic                     arm_wren,
  input  logic [4:0]               arm_awaddr,
  output logic                     cnt_wren,
  output logic [4:0]               cnt_awaddr,
  input  logic [COUNTER_WIDTH-1:0] counter0,
  input  logic [COUNTER_WIDTH-1:0] counter1,
  input  logic [COUNTER_WIDTH-1:0] counter2,
  input  logic [COUNTER_WIDTH-1:0] counter3,
  input  logic [COUNTER_WIDTH-1:0] counter4,
  input  logic [COUNTER_WIDTH-1:0] counter5,
  side_ch_counter_sched_if.master  m,
  output logic [15:0]              skip_cnt,
  output logic                     busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CAP, ST_SEND} state_e;

  state_e                    state_q, state_d;
  logic [PERIOD_WIDTH-1:0]   timer_q, timer_d;
  logic [2:0]                idx_q, idx_d;
  logic [7:0]                seq_q, seq_d;
  logic [15:0]               skip_q, skip_d;
  logic [COUNTER_WIDTH-1:0]  snap_q [6];
  logic [COUNTER_WIDTH-1:0]  cnt_sel;
  logic [PERIOD_WIDTH-1:0]   period_m1;
  logic                      tick;
  logic                      cap_en;
  logic                      sched_clr;
  logic                      in_send;

  assign period_m1 = period - PERIOD_WIDTH'(1);

  always_comb begin
    cnt_sel = counter0;
    case (idx_q)
      3'd1:    cnt_sel = counter1;
      3'd2:    cnt_sel = counter2;
      3'd3:    cnt_sel = counter3;
      3'd4:    cnt_sel = counter4;
      3'd5:    cnt_sel = counter5;
      default: cnt_sel = counter0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    skip_d    = skip_q;
    tick      = 1'b0;
    cap_en    = 1'b0;
    sched_clr = 1'b0;

    // New period values take effect only at reload, so a running interval is never disturbed.
    if (state_q != ST_IDLE) begin
      if (timer_q == '0) begin
        tick    = 1'b1;
        timer_d = period_m1;
      end else begin
        timer_d = timer_q - PERIOD_WIDTH'(1);
      end
    end

    if (tick && (state_q == ST_CAP || state_q == ST_SEND) && skip_q != 16'hFFFF)
      skip_d = skip_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (enable && period != '0) begin
          state_d = ST_WAIT;
          timer_d = period_m1;
        end
      end
      ST_WAIT: begin
        if (tick) begin
          state_d = ST_CAP;
          idx_d   = 3'd0;
        end else if (!enable || period == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_CAP: begin
        // ARM owns the clear bus this cycle; capture and clear must stay together, so both wait.
        if (!arm_wren) begin
          cap_en    = 1'b1;
          sched_clr = 1'b1;
          if (idx_q == 3'd5) begin
            idx_d   = 3'd0;
            state_d = ST_SEND;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_SEND: begin
        if (m.m_tready) begin
          if (idx_q == 3'd5) begin
            idx_d   = 3'd0;
            seq_d   = seq_q + 8'd1;
            state_d = enable ? ST_WAIT : ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= 3'd0;
      seq_q   <= 8'd0;
      skip_q  <= 16'd0;
      for (int i = 0; i < 6; i++) snap_q[i] <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      skip_q  <= skip_d;
      if (cap_en) snap_q[idx_q] <= cnt_sel;
    end
  end

  assign in_send    = (state_q == ST_SEND);
  assign m.m_tvalid = in_send;
  assign m.m_tlast  = in_send && (idx_q == 3'd5);
  assign m.m_tdata  = in_send ? {seq_q, idx_q, 5'b0, 16'(snap_q[idx_q])} : 32'd0;

  assign cnt_wren   = arm_wren | sched_clr;
  assign cnt_awaddr = sched_clr ? (5'd26 + {2'b00, idx_q}) : arm_awaddr;

  assign skip_cnt = skip_q;
  assign busy     = (state_q == ST_CAP) || (state_q == ST_SEND);

endmodule

// File: tb/tb_side_ch_counter_sched.sv
// Bench: scoreboard on stream beats, vector tables for the clear-bus mux, timed sequences for corner cases.
module tb_side_ch_counter_sched;
  localparam int CW = 16;
  localparam int PW = 24;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [PW-1:0]  period;
  logic           arm_wren;
  logic [4:0]     arm_awaddr;
  logic           cnt_wren;
  logic [4:0]     cnt_awaddr;
  logic [CW-1:0]  ctr [6];
  logic [15:0]    skip_cnt;
  logic           busy;

  side_ch_counter_sched_if s_if ();

  side_ch_counter_sched #(.COUNTER_WIDTH(CW), .PERIOD_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period),
    .arm_wren(arm_wren), .arm_awaddr(arm_awaddr),
    .cnt_wren(cnt_wren), .cnt_awaddr(cnt_awaddr),
    .counter0(ctr[0]), .counter1(ctr[1]), .counter2(ctr[2]),
    .counter3(ctr[3]), .counter4(ctr[4]), .counter5(ctr[5]),
    .m(s_if), .skip_cnt(skip_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] dat; logic last; } beat_t;
  typedef struct { int cyc; logic [4:0] addr; } clr_t;
  typedef struct { logic wr; logic [4:0] addr; logic exp_wr; logic [4:0] exp_addr; } vec_t;

  beat_t      exp_q [$];
  clr_t       clr_log [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc_n = 0;
  logic [7:0] exp_seq = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Inputs for the current cycle are final here; a valid&ready seen now completes at the next posedge.
  task automatic cyc();
    beat_t b;
    #1;
    if (s_if.m_tvalid === 1'b1 && s_if.m_tready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_unexpected: got tdata 0x%08h, expected no beat", s_if.m_tdata);
      end else begin
        b = exp_q.pop_front();
        chk("beat_tdata", s_if.m_tdata, b.dat);
        chk("beat_tlast", {31'd0, s_if.m_tlast}, {31'd0, b.last});
      end
    end
    if (cnt_wren === 1'b1) clr_log.push_back('{cyc_n, cnt_awaddr});
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic push_pkt();
    for (int i = 0; i < 6; i++)
      exp_q.push_back('{{exp_seq, 3'(i), 5'b0, 16'(ctr[i])}, (i == 5)});
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic wait_for(input string nm, input bit use_vld, input logic lvl, input int budget);
    int k = 0;
    while (((use_vld ? s_if.m_tvalid : busy) !== lvl) && k < budget) begin
      cyc();
      k++;
    end
    if ((use_vld ? s_if.m_tvalid : busy) !== lvl) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout after %0d cycles, got %b, expected %b", nm, budget,
               use_vld ? s_if.m_tvalid : busy, lvl);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    arm_wren = 1'b0;
    arm_awaddr = 5'd0;
    s_if.m_tready = 1'b1;
    cyc();
    rst = 1'b0;
    exp_q.delete();
    clr_log.delete();
    exp_seq = 8'd0;
    cyc_n = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected summary earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t arm_tbl [8];
    vec_t idle_tbl [4];
    int b0;
    logic [31:0] hold;
    bit ok;
    bit saw;

    arm_tbl = '{'{1'b0, 5'd0,  1'b1, 5'd26}, '{1'b0, 5'd0,  1'b1, 5'd27},
                '{1'b1, 5'd28, 1'b1, 5'd28}, '{1'b1, 5'd28, 1'b1, 5'd28},
                '{1'b0, 5'd0,  1'b1, 5'd28}, '{1'b0, 5'd0,  1'b1, 5'd29},
                '{1'b0, 5'd0,  1'b1, 5'd30}, '{1'b0, 5'd0,  1'b1, 5'd31}};
    idle_tbl = '{'{1'b0, 5'd5,  1'b0, 5'd5},  '{1'b1, 5'd3,  1'b1, 5'd3},
                 '{1'b1, 5'd31, 1'b1, 5'd31}, '{1'b0, 5'd17, 1'b0, 5'd17}};

    rst = 1'b1; enable = 1'b0; period = '0; arm_wren = 1'b0; arm_awaddr = 5'd0;
    s_if.m_tready = 1'b1;
    for (int i = 0; i < 6; i++) ctr[i] = '0;
    @(negedge clk);
    do_reset();
    chk("rst_tvalid", {31'd0, s_if.m_tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, s_if.m_tlast}, 32'd0);
    chk("rst_tdata", s_if.m_tdata, 32'd0);
    chk("rst_skip", {16'd0, skip_cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Basic snapshot, latency, clear sequence, and a second packet one period later.
    period = 100;
    for (int i = 0; i < 6; i++) ctr[i] = CW'(i + 1);
    push_pkt();
    enable = 1'b1;
    wait_for("t1_busy", 1'b0, 1'b1, 300);
    chk("t1_cap_start", cyc_n, 101);
    b0 = cyc_n;
    wait_for("t1_tvalid", 1'b1, 1'b1, 20);
    chk("t1_tvalid_lat", cyc_n - b0, 6);
    chk("t1_clr_n", clr_log.size(), 6);
    for (int i = 0; i < 6 && i < clr_log.size(); i++) begin
      chk("t1_clr_cyc", clr_log[i].cyc, b0 + i);
      chk("t1_clr_addr", {27'd0, clr_log[i].addr}, 26 + i);
    end
    wait_for("t1_done", 1'b0, 1'b0, 50);
    for (int i = 0; i < 6; i++) ctr[i] = CW'(i + 11);
    push_pkt();
    wait_for("t1_busy2", 1'b0, 1'b1, 200);
    chk("t1_period", cyc_n - b0, 100);
    enable = 1'b0;
    wait_for("t1_done2", 1'b0, 1'b0, 50);
    repeat (3) cyc();
    chk("t1_drain", exp_q.size(), 0);

    // Backpressure: 50-cycle stall in SEND with a 20-cycle period.
    do_reset();
    period = 20;
    for (int i = 0; i < 6; i++) ctr[i] = CW'(16'h100 + i);
    push_pkt();
    enable = 1'b1;
    wait_for("t2_tvalid", 1'b1, 1'b1, 100);
    chk("t2_first_beat", cyc_n, 27);
    cyc(); cyc();
    s_if.m_tready = 1'b0;
    hold = s_if.m_tdata;
    ok = 1'b1;
    repeat (50) begin
      if (s_if.m_tvalid !== 1'b1 || s_if.m_tdata !== hold || s_if.m_tlast !== 1'b0) ok = 1'b0;
      cyc();
    end
    chk("t2_stall_hold", {31'd0, ok}, 32'd1);
    s_if.m_tready = 1'b1;
    wait_for("t2_done", 1'b0, 1'b0, 20);
    chk("t2_end_cyc", cyc_n, 83);
    chk("t2_skip", {16'd0, skip_cnt}, 32'd3);
    enable = 1'b0;
    saw = 1'b0;
    repeat (30) begin
      if (busy !== 1'b0) saw = 1'b1;
      cyc();
    end
    chk("t2_no_extra", {31'd0, saw}, 32'd0);
    chk("t2_drain", exp_q.size(), 0);

    // ARM collision on the clear bus during capture of counter2.
    do_reset();
    period = 20;
    for (int i = 0; i < 6; i++) ctr[i] = CW'(16'hA0 + i);
    ctr[2] = 16'h3333;
    push_pkt();
    ctr[2] = 16'hA2;
    enable = 1'b1;
    wait_for("t3_busy", 1'b0, 1'b1, 100);
    for (int i = 0; i < 8; i++) begin
      arm_wren = arm_tbl[i].wr;
      arm_awaddr = arm_tbl[i].addr;
      if (i == 0) enable = 1'b0;
      if (i == 3) ctr[2] = 16'h3333;
      #1;
      chk("t3_wren", {31'd0, cnt_wren}, {31'd0, arm_tbl[i].exp_wr});
      chk("t3_addr", {27'd0, cnt_awaddr}, {27'd0, arm_tbl[i].exp_addr});
      cyc();
    end
    arm_wren = 1'b0;
    chk("t3_send", {31'd0, s_if.m_tvalid}, 32'd1);
    wait_for("t3_done", 1'b0, 1'b0, 20);
    chk("t3_drain", exp_q.size(), 0);

    // period=0 keeps the scheduler idle and the clear bus is a pure ARM pass-through.
    do_reset();
    period = 0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      arm_wren = idle_tbl[i].wr;
      arm_awaddr = idle_tbl[i].addr;
      #1;
      chk("t4_wren", {31'd0, cnt_wren}, {31'd0, idle_tbl[i].exp_wr});
      chk("t4_addr", {27'd0, cnt_awaddr}, {27'd0, idle_tbl[i].exp_addr});
      cyc();
    end
    arm_wren = 1'b0;
    repeat (20) cyc();
    chk("t4_idle", {31'd0, busy}, 32'd0);

    // Enable drop during SEND: packet completes, then idle with no further capture.
    do_reset();
    period = 20;
    for (int i = 0; i < 6; i++) ctr[i] = CW'(16'h5A00 + i);
    push_pkt();
    enable = 1'b1;
    wait_for("t5_tvalid", 1'b1, 1'b1, 100);
    cyc();
    enable = 1'b0;
    wait_for("t5_done", 1'b0, 1'b0, 20);
    chk("t5_end_cyc", cyc_n, 33);
    saw = 1'b0;
    repeat (40) begin
      if (busy !== 1'b0) saw = 1'b1;
      cyc();
    end
    chk("t5_stay_idle", {31'd0, saw}, 32'd0);
    chk("t5_drain", exp_q.size(), 0);

    // period=1: tick every cycle, one skip per busy cycle.
    do_reset();
    period = 1;
    for (int i = 0; i < 6; i++) ctr[i] = CW'(16'hFFF0 + i);
    push_pkt();
    enable = 1'b1;
    wait_for("t6_busy", 1'b0, 1'b1, 20);
    chk("t6_cap_start", cyc_n, 2);
    enable = 1'b0;
    wait_for("t6_done", 1'b0, 1'b0, 30);
    chk("t6_end_cyc", cyc_n, 14);
    chk("t6_skip", {16'd0, skip_cnt}, 32'd12);
    chk("t6_drain", exp_q.size(), 0);

    // Reset on beat 3 aborts the packet; the next packet restarts at index 0, seq 0.
    do_reset();
    period = 1;
    for (int i = 0; i < 6; i++) ctr[i] = CW'(16'h7700 + i);
    push_pkt();
    enable = 1'b1;
    wait_for("t7_tvalid", 1'b1, 1'b1, 20);
    cyc(); cyc(); cyc();
    chk("t7_skip_pre", {16'd0, skip_cnt}, 32'd9);
    s_if.m_tready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    s_if.m_tready = 1'b1;
    exp_q.delete();
    exp_seq = 8'd0;
    chk("t7_tvalid", {31'd0, s_if.m_tvalid}, 32'd0);
    chk("t7_skip", {16'd0, skip_cnt}, 32'd0);
    chk("t7_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) ctr[i] = CW'(16'h0C00 + i);
    push_pkt();
    wait_for("t7_busy2", 1'b0, 1'b1, 20);
    enable = 1'b0;
    wait_for("t7_done", 1'b0, 1'b0, 30);
    chk("t7_drain", exp_q.size(), 0);

    // 257 packets so seq wraps 255 -> 0, then a long stall saturates skip_cnt.
    do_reset();
    period = 1;
    for (int p = 0; p < 257; p++) begin
      for (int i = 0; i < 6; i++) ctr[i] = CW'(p * 7 + i);
      push_pkt();
      enable = 1'b1;
      wait_for("t8_busy", 1'b0, 1'b1, 10);
      enable = 1'b0;
      wait_for("t8_done", 1'b0, 1'b0, 30);
    end
    chk("t8_wrap_drain", exp_q.size(), 0);
    chk("t8_skip_sum", {16'd0, skip_cnt}, 32'd3084);
    for (int i = 0; i < 6; i++) ctr[i] = CW'(16'hBEE0 + i);
    push_pkt();
    enable = 1'b1;
    wait_for("t8_tvalid", 1'b1, 1'b1, 20);
    s_if.m_tready = 1'b0;
    enable = 1'b0;
    repeat (63000) cyc();
    chk("t8_skip_sat", {16'd0, skip_cnt}, 32'h0000FFFF);
    s_if.m_tready = 1'b1;
    wait_for("t8_sat_done", 1'b0, 1'b0, 20);
    chk("t8_skip_hold", {16'd0, skip_cnt}, 32'h0000FFFF);
    chk("t8_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
